// File: rtl/pixel_clip_fifo.sv
// Screen-clipping pixel FIFO between a line/shape drawer and a VGA adapter.
// Show-ahead output, sticky drop flag, and a done pulse once the drawer has finished and the FIFO is empty.
module pixel_clip_fifo #(
    parameter int DEPTH    = 8,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 in_x,
    input  logic [6:0]                 in_y,
    input  logic [2:0]                 in_colour,
    input  logic                       in_plot,
    input  logic                       in_done,
    output logic                       in_ready,
    output logic [7:0]                 vga_x,
    output logic [6:0]                 vga_y,
    output logic [2:0]                 vga_colour,
    output logic                       vga_plot,
    input  logic                       vga_ready,
    output logic                       done,
    output logic                       overflow,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = 18;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [8:0]    X_LIM    = 9'(SCREEN_W);
    localparam logic [7:0]    Y_LIM    = 8'(SCREEN_H);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_FINISH
    } state_t;

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic          r_done;
    state_t        r_state;

    logic          w_in_ready;
    logic          w_in_bounds;
    logic          w_push;
    logic          w_pop;
    logic          w_not_empty;
    logic [EW-1:0] w_entry [DEPTH];
    logic [EW-1:0] w_head;

    // Readiness depends on registered occupancy only, so a full FIFO refuses
    // a pixel even in a cycle where the adapter is popping.
    assign w_in_ready  = (r_count < FULL_CNT);
    assign w_in_bounds = ({1'b0, in_x} < X_LIM) && ({1'b0, in_y} < Y_LIM);
    assign w_push      = in_plot && w_in_ready && w_in_bounds;
    assign w_not_empty = (r_count != '0);
    assign w_pop       = w_not_empty && vga_ready;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [7:0] r_x;
            logic [6:0] r_y;
            logic [2:0] r_colour;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_x      <= '0;
                    r_y      <= '0;
                    r_colour <= '0;
                end else if (w_push && (r_wr_ptr == AW'(gi))) begin
                    r_x      <= in_x;
                    r_y      <= in_y;
                    r_colour <= in_colour;
                end
            end

            assign w_entry[gi] = {r_x, r_y, r_colour};
        end
    endgenerate

    assign w_head = w_entry[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (in_plot && !w_in_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // A push in the cycle the FIFO reads empty keeps us draining, so a pixel
    // accepted alongside in_done is always delivered before the done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (in_done) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!w_not_empty && !w_push) begin
                        r_state <= ST_FINISH;
                        r_done  <= 1'b1;
                    end else begin
                        r_done  <= 1'b0;
                    end
                end
                ST_FINISH: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = w_in_ready;
    assign vga_plot   = w_not_empty;
    assign vga_x      = w_head[17:10];
    assign vga_y      = w_head[9:3];
    assign vga_colour = w_head[2:0];
    assign done       = r_done;
    assign overflow   = r_overflow;
    assign count      = r_count;

endmodule
